ball_position_pid_mc: RTL and testbench

Parametrised multi-axis PID position controller for the ball-and-plate loop. Each slow_clock strobe samples desired and actual ball position for NUM_AXES axes and computes one saturated actuator command per axis. One time-multiplexed datapath serves all axes, with integral anti-windup and a runtime gain interface. Sits between the position decoder (touch panel/camera) and the servo PWM generators.

---
 rtl/ball_ctrl_pkg.sv | 30 +++
 rtl/pid_mac_stage.sv | 55 +++++
 rtl/ball_position_pid_mc.sv | 219 +++++++++++++++++++++
 tb/tb_ball_position_pid_mc.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_ctrl_pkg.sv
// Shared definitions for the ball-and-plate PID position controller: FSM encoding,
// default command limits and the accumulator sizing rule.
package ball_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StErr,
        StMac,
        StSum,
        StSat,
        StCommit
    } state_t;

    localparam int unsigned DEF_CENTER  = 2048;
    localparam int unsigned DEF_CMD_MIN = 0;
    localparam int unsigned DEF_CMD_MAX = 4095;

    // Widest product plus two guard bits for the three-term sum.
    function automatic int unsigned acc_width(input int unsigned width,
                                              input int unsigned gain_w,
                                              input int unsigned int_w);
        int unsigned pw;
        int unsigned iw;
        pw = gain_w + 1 + width + 2;
        iw = gain_w + 1 + int_w;
        return ((pw > iw) ? pw : iw) + 2;
    endfunction

endpackage

// File: rtl/pid_mac_stage.sv
// Shared PID multiply stage: registers the three signed products, then forms the
// shifted sum u and the raw (unsaturated) command r combinationally.
module pid_mac_stage
    import ball_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned GAIN_W = 8,
    parameter int unsigned INT_W  = 16,
    parameter int unsigned SHIFT  = 4,
    parameter int unsigned CENTER = DEF_CENTER
) (
    input  logic                                            clock,
    input  logic                                            reset_n,
    input  logic                                            en,
    input  logic signed [WIDTH:0]                           e,
    input  logic signed [INT_W-1:0]                         i_new,
    input  logic signed [WIDTH+1:0]                         deriv,
    input  logic        [GAIN_W-1:0]                        kp,
    input  logic        [GAIN_W-1:0]                        ki,
    input  logic        [GAIN_W-1:0]                        kd,
    output logic signed [acc_width(WIDTH, GAIN_W, INT_W)-1:0] u,
    output logic signed [acc_width(WIDTH, GAIN_W, INT_W):0]   r
);

    localparam int unsigned ACC_W = acc_width(WIDTH, GAIN_W, INT_W);
    localparam int unsigned PW    = GAIN_W + WIDTH + 2;
    localparam int unsigned IW    = GAIN_W + INT_W + 1;
    localparam int unsigned DW    = GAIN_W + WIDTH + 3;
    localparam logic signed [ACC_W:0] CENTER_S = (ACC_W+1)'(CENTER);

    logic signed [PW-1:0]    p_q;
    logic signed [IW-1:0]    i_q;
    logic signed [DW-1:0]    d_q;
    logic signed [ACC_W-1:0] sum;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_q <= '0;
            i_q <= '0;
            d_q <= '0;
        end else if (en) begin
            // Gains are unsigned; a zero MSB makes them safe signed operands.
            p_q <= PW'($signed({1'b0, kp})) * PW'(e);
            i_q <= IW'($signed({1'b0, ki})) * IW'(i_new);
            d_q <= DW'($signed({1'b0, kd})) * DW'(deriv);
        end
    end

    always_comb begin
        sum = ACC_W'(p_q) + ACC_W'(i_q) + ACC_W'(d_q);
        u   = sum >>> SHIFT;
        r   = (ACC_W+1)'(u) + CENTER_S;
    end

endmodule

// File: rtl/ball_position_pid_mc.sv
// Multi-axis PID position controller: one strobe captures all axes, a shared
// datapath walks them in turn, and all saturated commands update together.
module ball_position_pid_mc
    import ball_ctrl_pkg::*;
#(
    parameter int unsigned NUM_AXES = 2,
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned GAIN_W   = 8,
    parameter int unsigned SHIFT    = 4,
    parameter int unsigned INT_W    = 16,
    parameter int unsigned INT_LIM  = 8192,
    parameter int unsigned CENTER   = DEF_CENTER,
    parameter int unsigned CMD_MIN  = DEF_CMD_MIN,
    parameter int unsigned CMD_MAX  = DEF_CMD_MAX
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      slow_clock,
    input  logic                      run,
    input  logic [GAIN_W-1:0]         kp,
    input  logic [GAIN_W-1:0]         ki,
    input  logic [GAIN_W-1:0]         kd,
    input  logic [NUM_AXES*WIDTH-1:0] desired_pos,
    input  logic [NUM_AXES*WIDTH-1:0] actual_pos,
    output logic [NUM_AXES*WIDTH-1:0] command,
    output logic                      o_val,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned ACC_W = acc_width(WIDTH, GAIN_W, INT_W);
    localparam int unsigned IDX_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam logic [IDX_W-1:0]      LAST     = IDX_W'(NUM_AXES - 1);
    localparam logic [WIDTH-1:0]      CENTER_W = WIDTH'(CENTER);
    localparam logic signed [INT_W:0] LIM_P    = (INT_W+1)'(INT_LIM);
    localparam logic signed [INT_W:0] LIM_N    = -LIM_P;
    localparam logic signed [ACC_W:0] CMAX_S   = (ACC_W+1)'(CMD_MAX);
    localparam logic signed [ACC_W:0] CMIN_S   = (ACC_W+1)'(CMD_MIN);
    localparam logic signed [ACC_W:0] CENTER_S = (ACC_W+1)'(CENTER);

    state_t                   state_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     slow_q;
    logic                     strobe;
    logic [GAIN_W-1:0]        kp_q, ki_q, kd_q;
    logic [WIDTH-1:0]         des_q    [NUM_AXES];
    logic [WIDTH-1:0]         act_q    [NUM_AXES];
    logic signed [INT_W-1:0]  integ_q  [NUM_AXES];
    logic signed [WIDTH:0]    eprev_q  [NUM_AXES];
    logic [WIDTH-1:0]         shadow_q [NUM_AXES];
    logic [WIDTH-1:0]         cmd_q    [NUM_AXES];

    logic signed [WIDTH:0]    e_c, e_q;
    logic signed [WIDTH+1:0]  deriv_c, deriv_q;
    logic signed [INT_W:0]    isum;
    logic signed [INT_W-1:0]  inew_c, inew_q;
    logic signed [ACC_W-1:0]  u_sum;
    logic signed [ACC_W:0]    r_sum, r_q;
    logic                     hi, lo, hold_integ;
    logic [WIDTH-1:0]         cmd_c;

    assign strobe = slow_clock & ~slow_q;

    always_comb begin
        e_c     = $signed({1'b0, des_q[idx_q]}) - $signed({1'b0, act_q[idx_q]});
        deriv_c = (WIDTH+2)'(e_c) - (WIDTH+2)'(eprev_q[idx_q]);
        isum    = (INT_W+1)'(integ_q[idx_q]) + (INT_W+1)'(e_c);
        if (isum > LIM_P) begin
            inew_c = INT_W'(LIM_P);
        end else if (isum < LIM_N) begin
            inew_c = INT_W'(LIM_N);
        end else begin
            inew_c = INT_W'(isum);
        end
    end

    always_comb begin
        hi = r_q > CMAX_S;
        lo = r_q < CMIN_S;
        if (hi) begin
            cmd_c = WIDTH'(CMD_MAX);
        end else if (lo) begin
            cmd_c = WIDTH'(CMD_MIN);
        end else begin
            cmd_c = r_q[WIDTH-1:0];
        end
        // Freeze the integrator only when the error pushes further into the limit.
        hold_integ = (hi && !e_q[WIDTH] && (e_q != '0)) || (lo && e_q[WIDTH]);
    end

    pid_mac_stage #(
        .WIDTH  (WIDTH),
        .GAIN_W (GAIN_W),
        .INT_W  (INT_W),
        .SHIFT  (SHIFT),
        .CENTER (CENTER)
    ) u_mac (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (state_q == StMac),
        .e       (e_q),
        .i_new   (inew_q),
        .deriv   (deriv_q),
        .kp      (kp_q),
        .ki      (ki_q),
        .kd      (kd_q),
        .u       (u_sum),
        .r       (r_sum)
    );

    always_comb begin
        if (state_q == StSum) begin
            assert (r_sum == (ACC_W+1)'(u_sum) + CENTER_S);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            slow_q  <= 1'b0;
            o_val   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            kp_q    <= '0;
            ki_q    <= '0;
            kd_q    <= '0;
            e_q     <= '0;
            deriv_q <= '0;
            inew_q  <= '0;
            r_q     <= '0;
            for (int a = 0; a < NUM_AXES; a++) begin
                des_q[a]    <= '0;
                act_q[a]    <= '0;
                integ_q[a]  <= '0;
                eprev_q[a]  <= '0;
                shadow_q[a] <= CENTER_W;
                cmd_q[a]    <= CENTER_W;
            end
        end else begin
            slow_q <= slow_clock;
            o_val  <= 1'b0;
            if (!run) begin
                state_q <= StIdle;
                idx_q   <= '0;
                busy    <= 1'b0;
                overrun <= 1'b0;
                for (int a = 0; a < NUM_AXES; a++) begin
                    integ_q[a] <= '0;
                    eprev_q[a] <= '0;
                    cmd_q[a]   <= CENTER_W;
                end
            end else begin
                if (strobe && busy) begin
                    overrun <= 1'b1;
                end
                case (state_q)
                    StIdle: begin
                        if (strobe) begin
                            kp_q  <= kp;
                            ki_q  <= ki;
                            kd_q  <= kd;
                            for (int a = 0; a < NUM_AXES; a++) begin
                                des_q[a] <= desired_pos[a*WIDTH +: WIDTH];
                                act_q[a] <= actual_pos[a*WIDTH +: WIDTH];
                            end
                            idx_q   <= '0;
                            busy    <= 1'b1;
                            state_q <= StCapture;
                        end
                    end
                    StCapture: state_q <= StErr;
                    StErr: begin
                        e_q     <= e_c;
                        deriv_q <= deriv_c;
                        inew_q  <= inew_c;
                        state_q <= StMac;
                    end
                    StMac: state_q <= StSum;
                    StSum: begin
                        r_q     <= r_sum;
                        state_q <= StSat;
                    end
                    StSat: begin
                        shadow_q[idx_q] <= cmd_c;
                        eprev_q[idx_q]  <= e_q;
                        if (!hold_integ) begin
                            integ_q[idx_q] <= inew_q;
                        end
                        if (idx_q == LAST) begin
                            // Last axis bypasses its shadow so all axes land together.
                            for (int a = 0; a < NUM_AXES; a++) begin
                                cmd_q[a] <= (IDX_W'(a) == idx_q) ? cmd_c : shadow_q[a];
                            end
                            o_val   <= 1'b1;
                            state_q <= StCommit;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= StErr;
                        end
                    end
                    StCommit: begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    always_comb begin
        command = '0;
        for (int a = 0; a < NUM_AXES; a++) begin
            command[a*WIDTH +: WIDTH] = cmd_q[a];
        end
    end

endmodule

// File: tb/tb_ball_position_pid_mc.sv
// Bench for ball_position_pid_mc: per-cycle comparison against a strobe-level PID
// model, plus literal expectations for the directed scenarios.
module tb_ball_position_pid_mc;
    import ball_ctrl_pkg::*;

    localparam int N    = 2;
    localparam int W    = 12;
    localparam int GW   = 8;
    localparam int SH   = 2;
    localparam int IWD  = 16;
    localparam int LIM  = 8192;
    localparam int CTR  = DEF_CENTER;
    localparam int CMIN = DEF_CMD_MIN;
    localparam int CMAX = DEF_CMD_MAX;
    localparam int LAT  = 4 * N + 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          slow_clock = 1'b0;
    logic          run = 1'b0;
    logic [GW-1:0] kp = '0, ki = '0, kd = '0;
    logic [N*W-1:0] desired_pos = '0, actual_pos = '0;
    logic [N*W-1:0] command;
    logic          o_val, busy, overrun;

    ball_position_pid_mc #(
        .NUM_AXES (N),
        .WIDTH    (W),
        .GAIN_W   (GW),
        .SHIFT    (SH),
        .INT_W    (IWD),
        .INT_LIM  (LIM),
        .CENTER   (CTR),
        .CMD_MIN  (CMIN),
        .CMD_MAX  (CMAX)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .slow_clock  (slow_clock),
        .run         (run),
        .kp          (kp),
        .ki          (ki),
        .kd          (kd),
        .desired_pos (desired_pos),
        .actual_pos  (actual_pos),
        .command     (command),
        .o_val       (o_val),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    // Model state: integrators/history per axis, visible command, and the cycle count
    // since the accepted strobe (0 = idle).
    longint m_integ [N];
    longint m_eprev [N];
    int     m_cmd   [N];
    int     m_pend  [N];
    int     m_k;
    bit     m_oval, m_ovr, m_prev;
    int     errors = 0;
    int     checks = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < N; a++) begin
            m_integ[a] = 0;
            m_eprev[a] = 0;
            m_cmd[a]   = CTR;
            m_pend[a]  = CTR;
        end
        m_k = 0; m_oval = 0; m_ovr = 0; m_prev = 0;
    endtask

    task automatic model_compute();
        longint e, d, inew, s, u, r;
        for (int a = 0; a < N; a++) begin
            e    = longint'(desired_pos[a*W +: W]) - longint'(actual_pos[a*W +: W]);
            d    = e - m_eprev[a];
            inew = m_integ[a] + e;
            if (inew > LIM) inew = LIM;
            if (inew < -LIM) inew = -LIM;
            s = longint'(kp) * e + longint'(ki) * inew + longint'(kd) * d;
            u = s >>> SH;
            r = CTR + u;
            m_pend[a] = (r > CMAX) ? CMAX : (r < CMIN) ? CMIN : int'(r);
            if (!((r > CMAX && e > 0) || (r < CMIN && e < 0))) m_integ[a] = inew;
            m_eprev[a] = e;
        end
    endtask

    task automatic model_edge();
        bit stb;
        if (!reset_n) begin
            model_reset();
            return;
        end
        stb    = slow_clock && !m_prev;
        m_prev = slow_clock;
        m_oval = 0;
        if (!run) begin
            for (int a = 0; a < N; a++) begin
                m_integ[a] = 0;
                m_eprev[a] = 0;
                m_cmd[a]   = CTR;
            end
            m_k = 0; m_ovr = 0;
            return;
        end
        if (m_k != 0) begin
            if (stb) m_ovr = 1;
            if (m_k == LAT) begin
                m_k = 0;
            end else begin
                m_k++;
                if (m_k == LAT) begin
                    m_cmd  = m_pend;
                    m_oval = 1;
                end
            end
        end else if (stb) begin
            model_compute();
            m_k = 1;
        end
    endtask

    task automatic compare();
        for (int a = 0; a < N; a++) begin
            check($sformatf("command[%0d]", a), longint'(command[a*W +: W]), m_cmd[a]);
        end
        check("o_val", o_val, m_oval);
        check("busy", busy, m_k != 0);
        check("overrun", overrun, m_ovr);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare();
    endtask

    task automatic set_pos(input int d0, input int a0, input int d1, input int a1);
        desired_pos = {W'(d1), W'(d0)};
        actual_pos  = {W'(a1), W'(a0)};
    endtask

    task automatic fire();
        slow_clock = 1'b1;
        step();
        slow_clock = 1'b0;
        repeat (LAT + 1) step();
    endtask

    task automatic clear_loop();
        run = 1'b0;
        step();
        run = 1'b1;
    endtask

    task automatic lit_cmds(input string name, input int c0, input int c1);
        check({name, "_ax0"}, longint'(command[W-1:0]), c0);
        check({name, "_ax1"}, longint'(command[2*W-1:W]), c1);
    endtask

    int pulses;
    int dv, av;

    initial begin
        model_reset();
        repeat (2) step();
        lit_cmds("reset", 2048, 2048);
        check("reset_oval", o_val, 0);
        check("reset_busy", busy, 0);
        check("reset_ovr", overrun, 0);
        reset_n = 1'b1;
        run     = 1'b1;
        step();

        // P-only step with latency pin.
        kp = 8'd4; ki = '0; kd = '0;
        set_pos(2048, 1314, 1000, 1000);
        slow_clock = 1'b1;
        step();
        slow_clock = 1'b0;
        repeat (LAT - 2) step();
        check("lat_before", o_val, 0);
        step();
        check("lat_at", o_val, 1);
        lit_cmds("pstep", 2782, 2048);
        repeat (2) step();

        // Reset three cycles into a computation.
        set_pos(3000, 1000, 500, 2500);
        slow_clock = 1'b1;
        step();
        slow_clock = 1'b0;
        repeat (2) step();
        reset_n = 1'b0;
        repeat (2) step();
        check("rstmid_busy", busy, 0);
        lit_cmds("rstmid", 2048, 2048);
        reset_n = 1'b1;
        pulses = 0;
        repeat (LAT + 2) begin
            step();
            pulses += int'(o_val);
        end
        check("rstmid_pulses", pulses, 0);

        // Saturation with anti-windup.
        clear_loop();
        kp = 8'd32; ki = 8'd4; kd = '0;
        set_pos(4095, 0, 4095, 0);
        repeat (3) begin
            fire();
            lit_cmds("sat", 4095, 4095);
        end
        set_pos(2000, 2000, 2000, 2000);
        fire();
        lit_cmds("sat_release", 2048, 2048);

        // Integral accumulation and run=0 clear.
        clear_loop();
        kp = '0; ki = 8'd4; kd = '0;
        set_pos(1010, 1000, 1010, 1000);
        fire(); lit_cmds("integ1", 2058, 2058);
        fire(); lit_cmds("integ2", 2068, 2068);
        fire(); lit_cmds("integ3", 2078, 2078);
        run = 1'b0;
        step();
        lit_cmds("integ_stop", 2048, 2048);
        run = 1'b1;
        fire(); lit_cmds("integ_restart", 2058, 2058);

        // Derivative.
        clear_loop();
        kp = '0; ki = '0; kd = 8'd4;
        set_pos(1000, 1000, 1000, 1000);
        fire(); lit_cmds("deriv0", 2048, 2048);
        set_pos(1010, 1000, 1010, 1000);
        fire(); lit_cmds("deriv1", 2058, 2058);
        fire(); lit_cmds("deriv2", 2048, 2048);

        // Level-held strobe, then an edge while busy.
        pulses = 0;
        slow_clock = 1'b1;
        repeat (20) begin
            step();
            pulses += int'(o_val);
        end
        slow_clock = 1'b0;
        step();
        check("level_pulses", pulses, 1);
        slow_clock = 1'b1;
        step();
        slow_clock = 1'b0;
        repeat (2) step();
        slow_clock = 1'b1;
        step();
        slow_clock = 1'b0;
        check("ovr_set", overrun, 1);
        repeat (LAT + 2) step();
        check("ovr_sticky", overrun, 1);
        run = 1'b0;
        step();
        check("ovr_clear", overrun, 0);
        run = 1'b1;
        step();

        // Randomised traffic; inputs change while busy to exercise capture.
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                kp = GW'($urandom_range(0, 15));
                ki = GW'($urandom_range(0, 15));
                kd = GW'($urandom_range(0, 15));
            end else begin
                kp = GW'($urandom);
                ki = GW'($urandom);
                kd = GW'($urandom);
            end
            for (int a = 0; a < N; a++) begin
                dv = int'($urandom_range(0, 4095));
                if ($urandom_range(0, 1) == 0) begin
                    av = dv + int'($urandom_range(0, 64)) - 32;
                    if (av < 0) av = 0;
                    if (av > 4095) av = 4095;
                end else begin
                    av = int'($urandom_range(0, 4095));
                end
                desired_pos[a*W +: W] = W'(dv);
                actual_pos[a*W +: W]  = W'(av);
            end
            case ($urandom_range(0, 24))
                0: clear_loop();
                1: begin
                    reset_n = 1'b0;
                    step();
                    reset_n = 1'b1;
                end
                default: ;
            endcase
            slow_clock = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            slow_clock = 1'b0;
            repeat ($urandom_range(0, 13)) step();
        end
        repeat (LAT + 2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
